// File: rtl/num_join_if.sv
// Handshake/data bundle between the digit-entry logic (master) and num_join (slave).
// The optional neg input exists only when NUM_JOIN_NEG_EN is defined.
interface num_join_if;
  // start is a request sampled only while the assembler is idle; done is a
  // single-cycle completion strobe that qualifies out_num and err.
  logic        start;
  logic        sp;
  logic [3:0]  d0, d1, d2, d3, d4, d5, d6, d7;
`ifdef NUM_JOIN_NEG_EN
  logic        neg;
`endif
  logic        busy;
  logic        done;
  logic [31:0] out_num;
  logic        err;
  logic [1:0]  dbg_state;

  modport master (
    output start, sp, d0, d1, d2, d3, d4, d5, d6, d7,
`ifdef NUM_JOIN_NEG_EN
    output neg,
`endif
    input  busy, done, out_num, err, dbg_state
  );

  modport slave (
    input  start, sp, d0, d1, d2, d3, d4, d5, d6, d7,
`ifdef NUM_JOIN_NEG_EN
    input  neg,
`endif
    output busy, done, out_num, err, dbg_state
  );
endinterface

// File: rtl/num_join.sv
// Sequential eight-digit (BCD or hex) to 32-bit binary assembler, MSD first, one digit per cycle.
// Optional NUM_JOIN_NEG_EN adds a neg input that two's-complements decimal results.
module num_join (
  input  logic      clk,
  input  logic      rst,
  num_join_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  idx_q, idx_d;
  logic        err_acc_q, err_acc_d;
  logic [31:0] dig_q, dig_d;
  logic        sp_q, sp_d;
  logic        neg_q, neg_d;
  logic [31:0] out_num_q, out_num_d;
  logic        err_q, err_d;

  logic [3:0]  cur_dig;
  logic [31:0] acc_step;
  logic        err_step;
  logic        neg_in;

`ifdef NUM_JOIN_NEG_EN
  assign neg_in = bus.neg;
`else
  assign neg_in = 1'b0;
`endif

  // Decimal step is acc*10 built from two shifts so no constant multiplier is needed.
  always_comb begin
    cur_dig  = dig_q[{idx_q, 2'b00} +: 4];
    acc_step = sp_q ? {acc_q[27:0], cur_dig}
                    : (acc_q << 3) + (acc_q << 1) + {28'd0, cur_dig};
    err_step = err_acc_q | (~sp_q & (cur_dig > 4'd9));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    err_acc_d = err_acc_q;
    dig_d     = dig_q;
    sp_d      = sp_q;
    neg_d     = neg_q;
    out_num_d = out_num_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dig_d     = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
          sp_d      = bus.sp;
          neg_d     = neg_in;
          acc_d     = 32'd0;
          idx_d     = 3'd7;
          err_acc_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d     = acc_step;
        err_acc_d = err_step;
        idx_d     = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          out_num_d = (!sp_q && neg_q) ? (~acc_step + 32'd1) : acc_step;
          err_d     = err_step;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= 32'd0;
      idx_q     <= 3'd0;
      err_acc_q <= 1'b0;
      dig_q     <= 32'd0;
      sp_q      <= 1'b0;
      neg_q     <= 1'b0;
      out_num_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      err_acc_q <= err_acc_d;
      dig_q     <= dig_d;
      sp_q      <= sp_d;
      neg_q     <= neg_d;
      out_num_q <= out_num_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.out_num   = out_num_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule
